// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP pixel back end.
//   fade_state_t : global fade controller states
//   FADE_*_DIR   : encoding of the fade_dir command bit
//   PIPE_LAT     : cycles from ycocg_in/sync inputs to r/g/b/sync outputs
package vdp_pkg;

   typedef enum logic [1:0] {IDLE, FADE_OUT, DARK, FADE_IN} fade_state_t;

   localparam logic FADE_IN_DIR  = 1'b0;
   localparam logic FADE_OUT_DIR = 1'b1;

   localparam int unsigned PIPE_LAT = 5;

endpackage

// File: rtl/ycocg_to_rgb.sv
// YCoCg -> RGB back half of the output pipe (stages S2..S5, four register stages).
// Inputs are the already-faded luma and raw chroma from the S1 register.
//   clk_pix, rst_pix : pixel clock, synchronous active-high reset
//   yf               : faded luma (unsigned, YW bits)
//   co, cg           : chroma (two's complement, CW bits)
//   mono, de         : per-pixel grey select and data enable, aligned with yf
//   r, g, b          : clamped colour scaled to OUTW bits, 0 when de is low
module ycocg_to_rgb #(
   parameter int unsigned YW   = 7,
   parameter int unsigned CW   = 8,
   parameter int unsigned OUTW = 8
) (
   input  logic            clk_pix,
   input  logic            rst_pix,
   input  logic [YW-1:0]   yf,
   input  logic [CW-1:0]   co,
   input  logic [CW-1:0]   cg,
   input  logic            mono,
   input  logic            de,
   output logic [OUTW-1:0] r,
   output logic [OUTW-1:0] g,
   output logic [OUTW-1:0] b
);

   // Two guard bits over chroma cover the full intermediate range, so nothing wraps before clamp.
   localparam int IW   = CW + 2;
   localparam int YMAX = 2**YW - 1;

   typedef logic signed [IW-1:0] iw_t;

   function automatic logic [OUTW-1:0] scale(input logic [YW-1:0] v);
      return OUTW'(v) << (OUTW - YW);
   endfunction

   function automatic logic [OUTW-1:0] clamp_scale(input iw_t v);
      logic [YW-1:0] c;
      if (v < 0)                c = '0;
      else if (v > iw_t'(YMAX)) c = YW'(YMAX);
      else                      c = v[YW-1:0];
      return scale(c);
   endfunction

   iw_t yf_x, co_x, cg_x;
   assign yf_x = iw_t'(yf);
   assign co_x = iw_t'($signed(co));
   assign cg_x = iw_t'($signed(cg));

   // S2
   iw_t           tmp2_q, co2_q, cg2_q;
   logic [YW-1:0] yf2_q;
   logic          mono2_q, de2_q;
   // S3
   iw_t           g3_q, b3_q, co3_q;
   logic [YW-1:0] yf3_q;
   logic          mono3_q, de3_q;
   // S4
   iw_t           r4_q, g4_q, b4_q;
   logic [YW-1:0] yf4_q;
   logic          mono4_q, de4_q;

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         tmp2_q <= '0; co2_q <= '0; cg2_q <= '0; yf2_q <= '0; mono2_q <= 1'b0; de2_q <= 1'b0;
         g3_q   <= '0; b3_q  <= '0; co3_q <= '0; yf3_q <= '0; mono3_q <= 1'b0; de3_q <= 1'b0;
         r4_q   <= '0; g4_q  <= '0; b4_q  <= '0; yf4_q <= '0; mono4_q <= 1'b0; de4_q <= 1'b0;
         r      <= '0; g     <= '0; b     <= '0;
      end else begin
         tmp2_q  <= yf_x - (cg_x >>> 1);
         co2_q   <= co_x;
         cg2_q   <= cg_x;
         yf2_q   <= yf;
         mono2_q <= mono;
         de2_q   <= de;

         g3_q    <= cg2_q + tmp2_q;
         b3_q    <= tmp2_q - (co2_q >>> 1);
         co3_q   <= co2_q;
         yf3_q   <= yf2_q;
         mono3_q <= mono2_q;
         de3_q   <= de2_q;

         r4_q    <= b3_q + co3_q;
         g4_q    <= g3_q;
         b4_q    <= b3_q;
         yf4_q   <= yf3_q;
         mono4_q <= mono3_q;
         de4_q   <= de3_q;

         if (!de4_q) begin
            r <= '0; g <= '0; b <= '0;
         end else if (mono4_q) begin
            r <= scale(yf4_q); g <= scale(yf4_q); b <= scale(yf4_q);
         end else begin
            r <= clamp_scale(r4_q); g <= clamp_scale(g4_q); b <= clamp_scale(b4_q);
         end
      end
   end

endmodule

// File: rtl/ycocg_output_pipe.sv
// Pixel-clock back end: global frame-stepped fade, YCoCg->RGB (or mono), clamp, scale,
// with sync/coords delayed to the same fixed latency.
//   clk_pix, rst_pix           : pixel clock, synchronous active-high reset
//   sx_in, sy_in, de_in,
//   hsync_in, vsync_in         : timing aligned with ycocg_in
//   frame                      : frame-start pulse, steps the fade level
//   ycocg_in                   : {Y, Co, Cg}, Y in MSBs
//   mono                       : grey output from faded Y
//   fade_req, fade_dir,
//   fade_step                  : fade command strobe, direction, per-frame level change
//   fade_busy, fade_dark       : registered fade status
//   sx, sy, de, hsync, vsync   : delayed timing
//   r, g, b                    : output colour
module ycocg_output_pipe
   import vdp_pkg::*;
#(
   parameter int unsigned CORDW = 11,
   parameter int unsigned YW    = 7,
   parameter int unsigned CW    = 8,
   parameter int unsigned OUTW  = 8
) (
   input  logic               clk_pix,
   input  logic               rst_pix,
   input  logic [CORDW-1:0]   sx_in,
   input  logic [CORDW-1:0]   sy_in,
   input  logic               de_in,
   input  logic               hsync_in,
   input  logic               vsync_in,
   input  logic               frame,
   input  logic [YW+2*CW-1:0] ycocg_in,
   input  logic               mono,
   input  logic               fade_req,
   input  logic               fade_dir,
   input  logic [YW-1:0]      fade_step,
   output logic               fade_busy,
   output logic               fade_dark,
   output logic [CORDW-1:0]   sx,
   output logic [CORDW-1:0]   sy,
   output logic               de,
   output logic               hsync,
   output logic               vsync,
   output logic [OUTW-1:0]    r,
   output logic [OUTW-1:0]    g,
   output logic [OUTW-1:0]    b
);

   localparam logic [YW-1:0] LMAX = '1;
   localparam int unsigned   SW   = 2*CORDW + 3;

   // ---------------- fade controller ----------------
   fade_state_t   state_q, state_d;
   logic [YW-1:0] level_q, level_d;
   logic [YW:0]   level_up;

   assign level_up = {1'b0, level_q} + {1'b0, fade_step};

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      if (fade_req) begin
         // A command always consumes the cycle; a coincident frame pulse does not step.
         if (fade_dir == FADE_OUT_DIR && (state_q == IDLE || state_q == FADE_IN)) begin
            state_d = FADE_OUT;
         end else if (fade_dir == FADE_IN_DIR && (state_q == DARK || state_q == FADE_OUT)) begin
            state_d = FADE_IN;
         end
      end else if (frame && fade_step != '0) begin
         case (state_q)
            FADE_OUT: begin
               if (level_up >= {1'b0, LMAX}) begin
                  level_d = LMAX;
                  state_d = DARK;
               end else begin
                  level_d = level_up[YW-1:0];
               end
            end
            FADE_IN: begin
               if (level_q <= fade_step) begin
                  level_d = '0;
                  state_d = IDLE;
               end else begin
                  level_d = level_q - fade_step;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         state_q   <= IDLE;
         level_q   <= '0;
         fade_busy <= 1'b0;
         fade_dark <= 1'b0;
      end else begin
         state_q   <= state_d;
         level_q   <= level_d;
         fade_busy <= (state_q == FADE_OUT) || (state_q == FADE_IN);
         fade_dark <= (state_q == DARK);
      end
   end

   // ---------------- S1: fade applied to luma ----------------
   logic [YW-1:0] y_in, yf_d, yf_q;
   logic [CW-1:0] co_q, cg_q;
   logic          mono_q, de1_q;

   assign y_in = ycocg_in[YW+2*CW-1 -: YW];
   assign yf_d = (y_in > level_q) ? y_in - level_q : '0;

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         yf_q   <= '0;
         co_q   <= '0;
         cg_q   <= '0;
         mono_q <= 1'b0;
         de1_q  <= 1'b0;
      end else begin
         yf_q   <= yf_d;
         co_q   <= ycocg_in[2*CW-1 -: CW];
         cg_q   <= ycocg_in[CW-1:0];
         mono_q <= mono;
         de1_q  <= de_in;
      end
   end

   ycocg_to_rgb #(
      .YW   (YW),
      .CW   (CW),
      .OUTW (OUTW)
   ) u_ycocg_to_rgb (
      .clk_pix (clk_pix),
      .rst_pix (rst_pix),
      .yf      (yf_q),
      .co      (co_q),
      .cg      (cg_q),
      .mono    (mono_q),
      .de      (de1_q),
      .r       (r),
      .g       (g),
      .b       (b)
   );

   // ---------------- timing delay line ----------------
   logic [SW-1:0] sync_dl [PIPE_LAT];

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         for (int i = 0; i < int'(PIPE_LAT); i++) sync_dl[i] <= '0;
      end else begin
         sync_dl[0] <= {sx_in, sy_in, de_in, hsync_in, vsync_in};
         for (int i = 1; i < int'(PIPE_LAT); i++) sync_dl[i] <= sync_dl[i-1];
      end
   end

   assign {sx, sy, de, hsync, vsync} = sync_dl[PIPE_LAT-1];

endmodule

// File: tb/tb_ycocg_output_pipe.sv
module tb_ycocg_output_pipe;

   logic        clk_pix = 1'b0;
   logic        rst_pix;
   logic [10:0] sx_in, sy_in;
   logic        de_in, hsync_in, vsync_in, frame;
   logic [22:0] ycocg_in;
   logic        mono, fade_req, fade_dir;
   logic [6:0]  fade_step;
   logic        fade_busy, fade_dark;
   logic [10:0] sx, sy;
   logic        de, hsync, vsync;
   logic [7:0]  r, g, b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_pix = ~clk_pix;

   ycocg_output_pipe #(
      .CORDW (11),
      .YW    (7),
      .CW    (8),
      .OUTW  (8)
   ) dut (
      .clk_pix   (clk_pix),
      .rst_pix   (rst_pix),
      .sx_in     (sx_in),
      .sy_in     (sy_in),
      .de_in     (de_in),
      .hsync_in  (hsync_in),
      .vsync_in  (vsync_in),
      .frame     (frame),
      .ycocg_in  (ycocg_in),
      .mono      (mono),
      .fade_req  (fade_req),
      .fade_dir  (fade_dir),
      .fade_step (fade_step),
      .fade_busy (fade_busy),
      .fade_dark (fade_dark),
      .sx        (sx),
      .sy        (sy),
      .de        (de),
      .hsync     (hsync),
      .vsync     (vsync),
      .r         (r),
      .g         (g),
      .b         (b)
   );

   typedef struct {
      logic [6:0] y;
      logic [7:0] co;
      logic [7:0] cg;
      logic       mono;
      logic       de;
      logic [7:0] er;
      logic [7:0] eg;
      logic [7:0] eb;
   } vec_t;

   vec_t vecs [9];

   task automatic tick();
      @(posedge clk_pix);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_rgb(input string name, input int er, input int eg, input int eb);
      check({name, ".r"}, int'(r), er);
      check({name, ".g"}, int'(g), eg);
      check({name, ".b"}, int'(b), eb);
   endtask

   task automatic set_pix(input logic [6:0] y, input logic [7:0] co, input logic [7:0] cg,
                          input logic m, input logic d);
      ycocg_in = {y, co, cg};
      mono     = m;
      de_in    = d;
   endtask

   task automatic fade_cmd(input logic dir, input logic with_frame);
      fade_req = 1'b1;
      fade_dir = dir;
      frame    = with_frame;
      tick();
      fade_req = 1'b0;
      frame    = 1'b0;
   endtask

   task automatic frame_pulse();
      frame = 1'b1;
      tick();
      frame = 1'b0;
   endtask

   task automatic settle();
      repeat (6) tick();
   endtask

   task automatic do_reset();
      rst_pix = 1'b1;
      tick();
      rst_pix = 1'b0;
   endtask

   initial begin
      // y, co, cg, mono, de, r, g, b
      vecs[0] = '{7'd64,  8'd0,   8'd0,   1'b0, 1'b1, 8'd128, 8'd128, 8'd128};
      vecs[1] = '{7'd64,  8'd32,  8'd0,   1'b0, 1'b1, 8'd160, 8'd128, 8'd96};
      vecs[2] = '{7'd64,  8'd32,  8'd0,   1'b1, 1'b1, 8'd128, 8'd128, 8'd128};
      vecs[3] = '{7'd127, 8'd0,   8'd127, 1'b0, 1'b1, 8'd128, 8'd254, 8'd128};
      vecs[4] = '{7'd0,   8'hC0,  8'd0,   1'b0, 1'b1, 8'd0,   8'd0,   8'd64};
      vecs[5] = '{7'd127, 8'd0,   8'd0,   1'b0, 1'b0, 8'd0,   8'd0,   8'd0};
      vecs[6] = '{7'd127, 8'h80,  8'h80,  1'b0, 1'b1, 8'd254, 8'd126, 8'd254};
      vecs[7] = '{7'd0,   8'd127, 8'd127, 1'b0, 1'b1, 8'd2,   8'd128, 8'd0};
      vecs[8] = '{7'd100, 8'hEC,  8'd50,  1'b0, 1'b1, 8'd130, 8'd250, 8'd170};

      rst_pix = 1'b1;
      sx_in = '0; sy_in = '0; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
      frame = 1'b0; ycocg_in = '0; mono = 1'b0;
      fade_req = 1'b0; fade_dir = 1'b0; fade_step = 7'd16;
      repeat (3) tick();

      // Reset state
      check_rgb("reset", 0, 0, 0);
      check("reset.de", int'(de), 0);
      check("reset.busy", int'(fade_busy), 0);
      check("reset.dark", int'(fade_dark), 0);
      rst_pix = 1'b0;
      tick();

      // Single-cycle pixel: exact 5-cycle latency for colour and timing
      set_pix(7'd64, 8'd0, 8'd0, 1'b0, 1'b1);
      sx_in = 11'd5; sy_in = 11'd7; hsync_in = 1'b1; vsync_in = 1'b1;
      tick();
      set_pix(7'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      sx_in = '0; sy_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
      repeat (3) tick();
      check("lat4.r", int'(r), 0);
      check("lat4.de", int'(de), 0);
      tick();
      check_rgb("lat5", 128, 128, 128);
      check("lat5.sx", int'(sx), 5);
      check("lat5.sy", int'(sy), 7);
      check("lat5.de", int'(de), 1);
      check("lat5.hsync", int'(hsync), 1);
      check("lat5.vsync", int'(vsync), 1);
      tick();
      check("lat6.r", int'(r), 0);
      check("lat6.sx", int'(sx), 0);

      // Table-driven colour vectors
      for (int i = 0; i < 9; i++) begin
         set_pix(vecs[i].y, vecs[i].co, vecs[i].cg, vecs[i].mono, vecs[i].de);
         repeat (5) tick();
         check_rgb($sformatf("vec%0d", i), int'(vecs[i].er), int'(vecs[i].eg),
                   int'(vecs[i].eb));
      end

      // Fade out, step 16: levels 16..112 then saturate at 127 -> DARK
      set_pix(7'd127, 8'd0, 8'd0, 1'b0, 1'b1);
      fade_step = 7'd16;
      fade_cmd(1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         frame_pulse();
         settle();
         check($sformatf("fadeout%0d.r", i), int'(r), (i < 7) ? 2 * (127 - 16 * (i + 1)) : 0);
         check($sformatf("fadeout%0d.busy", i), int'(fade_busy), (i < 7) ? 1 : 0);
      end
      check("dark.flag", int'(fade_dark), 1);
      set_pix(7'd64, 8'd0, 8'd0, 1'b0, 1'b1);
      settle();
      check_rgb("dark.y64", 0, 0, 0);
      fade_cmd(1'b1, 1'b0);
      settle();
      check("dark.ignore_out", int'(fade_dark), 1);

      // Reversal at level 48, command coinciding with a frame pulse does not step
      do_reset();
      set_pix(7'd127, 8'd0, 8'd0, 1'b0, 1'b1);
      fade_cmd(1'b1, 1'b0);
      repeat (3) frame_pulse();
      settle();
      check("rev.l48.r", int'(r), 158);
      fade_step = 7'd0;
      frame_pulse();
      settle();
      check("step0.r", int'(r), 158);
      check("step0.busy", int'(fade_busy), 1);
      fade_step = 7'd16;
      fade_cmd(1'b0, 1'b1);
      settle();
      check("rev.nostep.r", int'(r), 158);
      check("rev.busy", int'(fade_busy), 1);
      for (int i = 0; i < 3; i++) begin
         frame_pulse();
         settle();
         check($sformatf("fadein%0d.r", i), int'(r), 2 * (127 - 48 + 16 * (i + 1)));
      end
      check("fadein.idle.busy", int'(fade_busy), 0);
      check("fadein.idle.dark", int'(fade_dark), 0);
      fade_cmd(1'b0, 1'b0);
      settle();
      check("idle.ignore_in", int'(fade_busy), 0);

      // Mid-line reset while fading
      sx_in = 11'd3; hsync_in = 1'b1;
      fade_cmd(1'b1, 1'b0);
      frame_pulse();
      settle();
      check("pre_rst.r", int'(r), 222);
      rst_pix = 1'b1;
      tick();
      check_rgb("midrst", 0, 0, 0);
      check("midrst.de", int'(de), 0);
      check("midrst.sx", int'(sx), 0);
      check("midrst.hsync", int'(hsync), 0);
      rst_pix = 1'b0;
      tick();
      check("midrst.busy", int'(fade_busy), 0);
      settle();
      check("post_rst.level0.r", int'(r), 254);
      check("post_rst.sx", int'(sx), 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
